lstm_seq_ctrl: RTL

//  Sequencer on the feedback side of the combinational LSTM cell. Accepts one input

---
 rtl/lstm_seq_ctrl_if.sv | 27 ++
 rtl/lstm_seq_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl_if.sv
// Stream bundle for the LSTM sequencer: X sample input stream and h/c result output stream.
// The sequencer uses the slave modport; the environment (source/sink) uses master.
interface lstm_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STEP_W     = 16
) ();
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_last;
  logic                  h_valid;
  logic                  h_ready;
  logic [DATA_WIDTH-1:0] h_data;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  h_last;
  logic [STEP_W-1:0]     step_idx;

  modport master (
    output x_valid, x_data, x_last, h_ready,
    input  x_ready, h_valid, h_data, c_data, h_last, step_idx
  );

  modport slave (
    input  x_valid, x_data, x_last, h_ready,
    output x_ready, h_valid, h_data, c_data, h_last, step_idx
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Feedback sequencer for a combinational LSTM cell: feeds X/c/h, waits a fixed settle
// time, captures the cell outputs and recirculates them on the following step.
module lstm_seq_ctrl #(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter int unsigned           FRACT_WIDTH   = 8,
  parameter int unsigned           SETTLE_CYCLES = 2,
  parameter int unsigned           STEP_W        = 16,
  parameter logic [DATA_WIDTH-1:0] C_INIT        = '0,
  parameter logic [DATA_WIDTH-1:0] H_INIT        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  lstm_seq_ctrl_if.slave        io,
  input  logic                  clear_state,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || FRACT_WIDTH > DATA_WIDTH) begin : g_param_chk
    $error("lstm_seq_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUT
  } state_t;

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic                  last_q;
  logic                  x_ready_q;
  logic                  h_valid_q;
  logic [DATA_WIDTH-1:0] cell_x_q;
  logic [DATA_WIDTH-1:0] c_in_q;
  logic [DATA_WIDTH-1:0] h_in_q;
  logic [DATA_WIDTH-1:0] h_data_q;
  logic [DATA_WIDTH-1:0] c_data_q;
  logic                  h_last_q;
  logic [STEP_W-1:0]     step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      x_ready_q <= 1'b1;
      h_valid_q <= 1'b0;
      cell_x_q  <= '0;
      c_in_q    <= C_INIT;
      h_in_q    <= H_INIT;
      h_data_q  <= '0;
      c_data_q  <= '0;
      h_last_q  <= 1'b0;
      step_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Clear and accept may share an edge: the step then starts from init state.
          if (clear_state) begin
            c_in_q <= C_INIT;
            h_in_q <= H_INIT;
            step_q <= '0;
          end
          if (io.x_valid) begin
            cell_x_q  <= io.x_data;
            last_q    <= io.x_last;
            cnt_q     <= 8'(SETTLE_CYCLES);
            x_ready_q <= 1'b0;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 8'd1) begin
            h_data_q  <= cell_h_out;
            c_data_q  <= cell_c_out;
            h_last_q  <= last_q;
            h_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        OUT: begin
          if (io.h_ready) begin
            h_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            state_q   <= IDLE;
            if (last_q) begin
              c_in_q <= C_INIT;
              h_in_q <= H_INIT;
              step_q <= '0;
            end else begin
              c_in_q <= c_data_q;
              h_in_q <= h_data_q;
              step_q <= step_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          x_ready_q <= 1'b1;
          h_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.x_ready   = x_ready_q;
  assign io.h_valid   = h_valid_q;
  assign io.h_data    = h_data_q;
  assign io.c_data    = c_data_q;
  assign io.h_last    = h_last_q;
  assign io.step_idx  = step_q;
  assign cell_x       = cell_x_q;
  assign cell_c_in    = c_in_q;
  assign cell_h_in    = h_in_q;

endmodule
